// File: rtl/systemverilog_bus_mux_pkg.sv
// -----------------------------------------------------------------------------
// systemverilog_bus_mux_pkg
// Shared types for the bus-over-stream link (mux and demux side).
//   t_bus : one bus transaction, address in the MSBs, data in the LSBs.
//   t_str : the same 64 bits viewed as eight stream bytes, element 0 in the
//           LSBs, so beat k of a packet is element k.
// -----------------------------------------------------------------------------
package systemverilog_bus_mux_pkg;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } t_bus;

    typedef logic [7:0][7:0] t_str;

    localparam logic [2:0] LAST_BEAT = 3'd7;
    localparam logic [1:0] BUF_FULL  = 2'd2;
    localparam logic [1:0] BUF_EMPTY = 2'd0;

endpackage

// File: rtl/systemverilog_bus_mux_if.sv
// -----------------------------------------------------------------------------
// systemverilog_bus_mux_if
// Bus-side and stream-side handshake signals of the mux.
//   bus_vld/bus_adr/bus_dat/bus_rdy : 64-bit transaction port (valid/ready)
//   str_vld/str_bus/str_rdy         : 8-bit beat stream (valid/ready)
// Modports:
//   slave  : the mux (accepts bus transactions, sources the stream)
//   master : the environment (issues transactions, sinks the stream)
// -----------------------------------------------------------------------------
interface systemverilog_bus_mux_if;

    logic        bus_vld;
    logic [31:0] bus_adr;
    logic [31:0] bus_dat;
    logic        bus_rdy;
    logic        str_vld;
    logic [7:0]  str_bus;
    logic        str_rdy;

    modport slave (
        input  bus_vld, bus_adr, bus_dat, str_rdy,
        output bus_rdy, str_vld, str_bus
    );

    modport master (
        output bus_vld, bus_adr, bus_dat, str_rdy,
        input  bus_rdy, str_vld, str_bus
    );

endinterface

// File: rtl/systemverilog_bus_mux_buf.sv
// -----------------------------------------------------------------------------
// systemverilog_bus_mux_buf
// Two-entry packet buffer between the bus port and the serializer.
//   clk, rst  : clock, asynchronous active-high reset (control state only)
//   push_i    : write wdata_i into the tail entry
//   wdata_i   : transaction to store
//   pop_i     : retire the head entry
//   rdata_o   : head entry (selected by the registered read pointer)
//   cnt_o     : occupancy 0..2
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module systemverilog_bus_mux_buf
    import systemverilog_bus_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  t_bus       wdata_i,
    input  logic       pop_i,
    output t_bus       rdata_o,
    output logic [1:0] cnt_o
);

    t_bus       mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        cnt_d    = cnt_q;
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= BUF_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset; a stale entry is never visible because the
    // occupancy is cleared.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/systemverilog_bus_mux.sv
// -----------------------------------------------------------------------------
// systemverilog_bus_mux
// Serializes 64-bit bus transactions ({adr, dat}) into eight 8-bit stream
// beats, beat k = element k of t_str (beat 0 = dat[7:0], beat 7 = adr[31:24]).
// A two-entry buffer accepts the next transaction while the current one is
// streaming, so back-to-back packets stream without idle beats.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   port : systemverilog_bus_mux_if.slave (bus side in, stream side out)
// bus_rdy and str_vld depend on registered occupancy only; str_bus is a mux
// of buffer storage under registered indices.
// -----------------------------------------------------------------------------
module systemverilog_bus_mux
    import systemverilog_bus_mux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    systemverilog_bus_mux_if.slave port
);

    logic       bus_rdy;
    logic       str_vld;
    logic       bus_trn;
    logic       str_trn;
    logic       pop;
    logic [1:0] cnt;
    t_bus       wdata;
    t_bus       head;
    t_str       head_str;
    logic [2:0] beat_q, beat_d;

    assign bus_rdy = (cnt != BUF_FULL);
    assign str_vld = (cnt != BUF_EMPTY);
    assign bus_trn = port.bus_vld & bus_rdy;
    assign str_trn = str_vld & port.str_rdy;
    // The head packet retires when its last beat is taken.
    assign pop     = str_trn & (beat_q == LAST_BEAT);

    assign wdata.adr = port.bus_adr;
    assign wdata.dat = port.bus_dat;

    systemverilog_bus_mux_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus_trn),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .cnt_o   (cnt)
    );

    // Beat counter wraps 7 -> 0 naturally, aligning with the pop.
    always_comb begin
        beat_d = beat_q;
        if (str_trn) begin
            beat_d = beat_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= 3'd0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign head_str     = t_str'(head);
    assign port.str_bus = head_str[beat_q];
    assign port.str_vld = str_vld;
    assign port.bus_rdy = bus_rdy;

endmodule

// File: tb/tb_systemverilog_bus_mux.sv
// -----------------------------------------------------------------------------
// tb_systemverilog_bus_mux
// Directed bench for systemverilog_bus_mux: reset state, single packet,
// back-to-back packets with full-buffer stall, random stream backpressure,
// reset mid-packet and push coinciding with the last-beat pop.
// -----------------------------------------------------------------------------
module tb_systemverilog_bus_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;

    systemverilog_bus_mux_if bif ();

    systemverilog_bus_mux dut (
        .clk  (clk),
        .rst  (rst),
        .port (bif.slave)
    );

    always #5 clk = ~clk;

    int n_vec    = 0;
    int n_miscmp = 0;
    int cyc      = 0;

    logic       bp_en     = 1'b0;
    logic       bp_rnd    = 1'b0;
    logic       rdy_force = 1'b0;
    assign bif.str_rdy = bp_en ? bp_rnd : rdy_force;

    logic [7:0] got_b [$];
    int         got_c [$];
    logic [7:0] exp_b [$];
    logic       stall_q   = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] beat_of(input logic [31:0] a, input logic [31:0] d, input int k);
        logic [63:0] w;
        w = {a, d};
        return w[8*k +: 8];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        bp_rnd = 1'($urandom_range(0, 1));
    end

    // Stream monitor: logs accepted beats and checks that a stalled beat holds.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_q) begin
                check_eq("hold_vld", 64'(bif.str_vld), 64'd1);
                check_eq("hold_byte", 64'(bif.str_bus), 64'(hold_byte));
            end
            if (bif.str_vld && bif.str_rdy) begin
                got_b.push_back(bif.str_bus);
                got_c.push_back(cyc);
            end
            stall_q   = bif.str_vld && !bif.str_rdy;
            hold_byte = bif.str_bus;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Presents a transaction and returns (at #1 after the accepting edge) with
    // bus_vld still high; acc_cyc is the cycle count right after acceptance.
    task automatic offer(input logic [31:0] a, input logic [31:0] d, output int acc_cyc);
        bit acc;
        acc = 1'b0;
        bif.bus_vld = 1'b1;
        bif.bus_adr = a;
        bif.bus_dat = d;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = bif.bus_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("offer_timeout", 64'd0, 64'd1);
        acc_cyc = cyc;
        for (int k = 0; k < 8; k++) exp_b.push_back(beat_of(a, d, k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t;
        t = 0;
        while (got_b.size() < n && t < 3000) begin
            step();
            t++;
        end
        if (got_b.size() < n) check_eq(tag, 64'(got_b.size()), 64'(n));
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bif.str_vld && t < 3000) begin
            step();
            t++;
        end
        if (bif.str_vld) check_eq("idle_timeout", 64'd1, 64'd0);
        step();
    endtask

    task automatic clear_q();
        got_b.delete();
        got_c.delete();
        exp_b.delete();
    endtask

    task automatic cmp_bytes(input string tag);
        check_eq({tag, "_count"}, 64'(got_b.size()), 64'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            check_eq(tag, 64'(got_b[i]), 64'(exp_b[i]));
    endtask

    initial begin
        logic [7:0] e1 [8];
        int ca, cb, cc;

        e1 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};
        bif.bus_vld = 1'b0;
        bif.bus_adr = 32'h0;
        bif.bus_dat = 32'h0;

        // ---- reset state
        repeat (3) step();
        check_eq("rst_str_vld", 64'(bif.str_vld), 64'd0);
        check_eq("rst_bus_rdy", 64'(bif.bus_rdy), 64'd1);
        rst = 1'b0;
        rdy_force = 1'b1;
        step();
        check_eq("idle_str_vld", 64'(bif.str_vld), 64'd0);

        // ---- single transaction, cycle exact
        clear_q();
        offer(32'h11223344, 32'hAABBCCDD, ca);
        bif.bus_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_eq("single_vld", 64'(bif.str_vld), 64'd1);
            check_eq("single_byte", 64'(bif.str_bus), 64'(e1[k]));
            step();
        end
        check_eq("single_vld_after", 64'(bif.str_vld), 64'd0);
        cmp_bytes("single_mon");
        wait_idle();

        // ---- back-to-back, buffer fills, 24 beats without a gap
        clear_q();
        offer(32'h01020304, 32'h05060708, ca);
        offer(32'h10203040, 32'h50607080, cb);
        check_eq("b2b_rdy_after_2nd", 64'(bif.bus_rdy), 64'd0);
        check_eq("b2b_vld", 64'(bif.str_vld), 64'd1);
        offer(32'hCAFEF00D, 32'hDEADBEEF, cc);
        bif.bus_vld = 1'b0;
        check_eq("b2b_acc_2nd", 64'(cb - ca), 64'd1);
        check_eq("b2b_acc_3rd", 64'(cc - ca), 64'd9);
        check_eq("b2b_rdy_after_3rd", 64'(bif.bus_rdy), 64'd0);
        wait_beats(24, "b2b_timeout");
        if (got_c.size() > 0) check_eq("b2b_first_beat", 64'(got_c[0]), 64'(ca));
        for (int i = 1; i < 24 && i < got_c.size(); i++)
            check_eq("b2b_gap", 64'(got_c[i] - got_c[0]), 64'(i));
        cmp_bytes("b2b_bytes");
        wait_idle();

        // ---- random backpressure over 4 transactions
        clear_q();
        bp_en = 1'b1;
        offer(32'hA5A5A5A5, 32'h5A5A5A5A, ca);
        offer(32'h00FF00FF, 32'hFF00FF00, ca);
        offer(32'h89ABCDEF, 32'h01234567, ca);
        offer(32'h80000001, 32'h7FFFFFFE, ca);
        bif.bus_vld = 1'b0;
        wait_beats(32, "bp_timeout");
        cmp_bytes("bp_bytes");
        bp_en = 1'b0;
        wait_idle();

        // ---- reset mid-packet with a second packet buffered
        clear_q();
        offer(32'h12121212, 32'h34343434, ca);
        offer(32'h56565656, 32'h78787878, cb);
        bif.bus_vld = 1'b0;
        wait_beats(4, "rstmid_timeout");
        step();
        rst = 1'b1;
        bif.bus_vld = 1'b1;
        bif.bus_adr = 32'hEEEEEEEE;
        bif.bus_dat = 32'hEEEEEEEE;
        #1;
        check_eq("rstmid_str_vld", 64'(bif.str_vld), 64'd0);
        check_eq("rstmid_bus_rdy", 64'(bif.bus_rdy), 64'd1);
        step();
        step();
        bif.bus_vld = 1'b0;
        rst = 1'b0;
        step();
        check_eq("rstmid_post_vld", 64'(bif.str_vld), 64'd0);
        clear_q();
        offer(32'h9ABCDEF0, 32'h0FEDCBA9, cc);
        bif.bus_vld = 1'b0;
        check_eq("rstmid_c_beat0", 64'(bif.str_bus), 64'h0A9);
        repeat (12) step();
        cmp_bytes("rstmid_bytes");
        wait_idle();

        // ---- push coinciding with the last-beat pop at cnt == 1
        clear_q();
        offer(32'h31415926, 32'h27182818, ca);
        bif.bus_vld = 1'b0;
        repeat (7) step();
        check_eq("sim_head_beat7", 64'(bif.str_bus), 64'h31);
        offer(32'hB0B1B2B3, 32'hC0C1C2C3, cb);
        bif.bus_vld = 1'b0;
        check_eq("sim_same_edge", 64'(cb - ca), 64'd8);
        check_eq("sim_vld", 64'(bif.str_vld), 64'd1);
        check_eq("sim_rdy", 64'(bif.bus_rdy), 64'd1);
        check_eq("sim_beat0", 64'(bif.str_bus), 64'hC3);
        repeat (7) step();
        check_eq("sim_vld_last", 64'(bif.str_vld), 64'd1);
        check_eq("sim_beat7", 64'(bif.str_bus), 64'hB0);
        step();
        check_eq("sim_vld_end", 64'(bif.str_vld), 64'd0);
        cmp_bytes("sim_bytes");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
